ce_stopwatch: RTL and testbench

- Consumer of the one-cycle CE strobe from the system frequency divider; counts CE ticks into a 4-digit BCD stopwatch (SS.hh, 10 ms resolution at 1 kHz CE).
- Push-button control: START_STOP toggles run/pause; CLEAR zeroes the count while stopped.
- Outputs feed the 7-segment display multiplexer; a sticky overflow flag marks a wrap past 99.99.

---
 rtl/ce_stopwatch_pkg.sv | 14 +
 rtl/ce_stopwatch_bcd_decade.sv | 31 +++
 rtl/ce_stopwatch.sv | 191 +++++++++++++++++++
 tb/tb_ce_stopwatch.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ce_stopwatch_pkg.sv
// Shared constants for the CE-driven BCD stopwatch: FSM state codes,
// BCD digit limits and the button synchroniser depth.
package ce_stopwatch_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    localparam int         BCD_W   = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/ce_stopwatch_bcd_decade.sv
// One BCD decade of the stopwatch count chain: wraps 9 -> 0 and ripples a
// carry to the next decade in the same cycle.
module bcd_decade
    import ce_stopwatch_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             clr,
    input  logic             inc_in,
    output logic [BCD_W-1:0] digit,
    output logic             carry_out
);

    assign carry_out = inc_in & (digit == BCD_MAX);

    // Digit register: clear has priority, then increment with 9 -> 0 wrap.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            digit <= '0;
        end else if (clr) begin
            digit <= '0;
        end else if (inc_in) begin
            if (digit == BCD_MAX) begin
                digit <= '0;
            end else begin
                digit <= digit + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ce_stopwatch.sv
// CE-strobe stopwatch: START_STOP toggles run/pause, CLEAR zeroes the count
// while stopped, a prescaler divides CE into hundredths and a BCD decade
// chain holds the displayed count. OVF is sticky on wrap past all-9s.
// Optional lap freeze is compiled in with `define CE_STOPWATCH_LAP_EN.
module ce_stopwatch
    import ce_stopwatch_pkg::*;
#(
    parameter int PRESCALE = 10,
    parameter int DIGITS   = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CE,
    input  logic                  START_STOP,
    input  logic                  CLEAR,
`ifdef CE_STOPWATCH_LAP_EN
    input  logic                  LAP,
    output logic                  LAP_ACTIVE,
`endif
    output logic [4*DIGITS-1:0]   DIGITS_BCD,
    output logic                  RUNNING,
    output logic                  OVF
);

    // A prescale of 1 still needs a one-bit counter that simply stays at 0.
    localparam int            PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

`ifdef CE_STOPWATCH_LAP_EN
    localparam int NB = 3;
`else
    localparam int NB = 2;
`endif

    logic [NB-1:0]        btn_raw;
    logic [NB-1:0]        btn_sync [SYNC_STAGES];
    logic [NB-1:0]        btn_prev;
    logic [NB-1:0]        btn_edge;
    logic                 start_edge;
    logic                 clr_edge;
    logic [1:0]           state;
    logic [1:0]           state_nxt;
    logic                 clr_all;
    logic                 tick;
    logic                 inc;
    logic [PS_W-1:0]      pre;
    logic [DIGITS:0]      carry;
    logic [4*DIGITS-1:0]  live;
    logic                 running;
    logic                 ovf;

`ifdef CE_STOPWATCH_LAP_EN
    assign btn_raw = {LAP, CLEAR, START_STOP};
`else
    assign btn_raw = {CLEAR, START_STOP};
`endif

    // Button conditioning: synchroniser chain plus one flop for rising-edge detect.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                btn_sync[i] <= '0;
            end
            btn_prev <= '0;
        end else begin
            btn_sync[0] <= btn_raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                btn_sync[i] <= btn_sync[i-1];
            end
            btn_prev <= btn_sync[SYNC_STAGES-1];
        end
    end

    assign btn_edge   = btn_sync[SYNC_STAGES-1] & ~btn_prev;
    assign start_edge = btn_edge[0];
    assign clr_edge   = btn_edge[1];

    // Next-state logic; clear wins over start in PAUSE, and in IDLE a clear
    // is applied even when a start edge moves the state on to RUN.
    always_comb begin
        state_nxt = state;
        clr_all   = 1'b0;
        case (state)
            ST_IDLE: begin
                clr_all = clr_edge;
                if (start_edge) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (start_edge) begin
                    state_nxt = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (clr_edge) begin
                    state_nxt = ST_IDLE;
                    clr_all   = 1'b1;
                end else if (start_edge) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                clr_all   = 1'b1;
            end
        endcase
    end

    // State register with a registered copy of the RUN decode for the output.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= ST_IDLE;
            running <= 1'b0;
        end else begin
            state   <= state_nxt;
            running <= (state_nxt == ST_RUN);
        end
    end

    // A CE landing on the RUN->PAUSE edge is dropped, so pausing never
    // sneaks in one extra tick.
    assign tick = (state == ST_RUN) & CE & ~start_edge;
    assign inc  = tick & (pre == PS_LAST);

    // Prescaler: counts qualifying CE ticks, holds its value through PAUSE.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pre <= '0;
        end else if (clr_all) begin
            pre <= '0;
        end else if (tick) begin
            if (pre == PS_LAST) begin
                pre <= '0;
            end else begin
                pre <= pre + 1'b1;
            end
        end
    end

    assign carry[0] = inc;

    for (genvar g = 0; g < DIGITS; g++) begin : g_decade
        bcd_decade u_decade (
            .CLK       (CLK),
            .RST       (RST),
            .clr       (clr_all),
            .inc_in    (carry[g]),
            .digit     (live[g*BCD_W +: BCD_W]),
            .carry_out (carry[g+1])
        );
    end

    // Sticky overflow: set by the carry out of the top decade, cleared on entering IDLE.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ovf <= 1'b0;
        end else if (clr_all) begin
            ovf <= 1'b0;
        end else if (carry[DIGITS]) begin
            ovf <= 1'b1;
        end
    end

    assign RUNNING = running;
    assign OVF     = ovf;

`ifdef CE_STOPWATCH_LAP_EN
    logic                lap_active;
    logic [4*DIGITS-1:0] lap_hold;

    // Lap freeze: toggled by LAP in RUN, released by pausing or any clear edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lap_active <= 1'b0;
            lap_hold   <= '0;
        end else if (clr_edge || (state == ST_RUN && state_nxt == ST_PAUSE)) begin
            lap_active <= 1'b0;
        end else if (state == ST_RUN && btn_edge[2]) begin
            lap_active <= ~lap_active;
            lap_hold   <= live;
        end
    end

    assign LAP_ACTIVE = lap_active;
    assign DIGITS_BCD = lap_active ? lap_hold : live;
`else
    assign DIGITS_BCD = live;
`endif

endmodule

// File: tb/tb_ce_stopwatch.sv
// Directed bench for ce_stopwatch: one DUT at PRESCALE=10 for counting and
// control scenarios, one at PRESCALE=1 to reach the 99.99 wrap quickly.
// All inputs are shared; every scenario starts from a reset.
`timescale 1ns/1ps
module tb_ce_stopwatch;

    logic        clk;
    logic        rst;
    logic        ce;
    logic        ss;
    logic        clr;
    logic        lap;
    logic [15:0] d10;
    logic        run10;
    logic        ovf10;
    logic [15:0] d1;
    logic        run1;
    logic        ovf1;
    logic        lapa10;
    logic        lapa1;

    int total;
    int bad;

    ce_stopwatch #(.PRESCALE(10), .DIGITS(4)) dut (
        .CLK        (clk),
        .RST        (rst),
        .CE         (ce),
        .START_STOP (ss),
        .CLEAR      (clr),
`ifdef CE_STOPWATCH_LAP_EN
        .LAP        (lap),
        .LAP_ACTIVE (lapa10),
`endif
        .DIGITS_BCD (d10),
        .RUNNING    (run10),
        .OVF        (ovf10)
    );

    ce_stopwatch #(.PRESCALE(1), .DIGITS(4)) dut1 (
        .CLK        (clk),
        .RST        (rst),
        .CE         (ce),
        .START_STOP (ss),
        .CLEAR      (clr),
`ifdef CE_STOPWATCH_LAP_EN
        .LAP        (lap),
        .LAP_ACTIVE (lapa1),
`endif
        .DIGITS_BCD (d1),
        .RUNNING    (run1),
        .OVF        (ovf1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // All tasks start and end 1 ns after a rising edge.
    task automatic do_reset();
        rst = 1'b1;
        ce  = 1'b0;
        ss  = 1'b0;
        clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic ce_n(input int n);
        ce = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        ce = 1'b0;
    endtask

    task automatic press(input logic p_ss, input logic p_clr);
        ss  = p_ss;
        clr = p_clr;
        repeat (5) @(posedge clk);
        #1;
        ss  = 1'b0;
        clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ce  = 1'b0;
        ss  = 1'b0;
        clr = 1'b0;
        lap = 1'b0;
        #1;
        total++; if (d10 !== 16'h0000) begin bad++; $display("FAIL reset_digits got=%h exp=0000", d10); end
        total++; if (run10 !== 1'b0) begin bad++; $display("FAIL reset_running got=%b exp=0", run10); end
        total++; if (ovf10 !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf10); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_count();
        do_reset();
        press(1'b1, 1'b0);
        total++; if (run10 !== 1'b1) begin bad++; $display("FAIL count_start_running got=%b exp=1", run10); end
        ce_n(25);
        total++; if (d10 !== 16'h0002) begin bad++; $display("FAIL count_25ce got=%h exp=0002", d10); end
        total++; if (run10 !== 1'b1) begin bad++; $display("FAIL count_running got=%b exp=1", run10); end
        total++; if (ovf10 !== 1'b0) begin bad++; $display("FAIL count_ovf got=%b exp=0", ovf10); end
    endtask

    task automatic test_pause_resume();
        do_reset();
        press(1'b1, 1'b0);
        ce_n(23);
        total++; if (d10 !== 16'h0002) begin bad++; $display("FAIL pr_23ce got=%h exp=0002", d10); end
        press(1'b1, 1'b0);
        total++; if (run10 !== 1'b0) begin bad++; $display("FAIL pr_paused got=%b exp=0", run10); end
        ce_n(50);
        total++; if (d10 !== 16'h0002) begin bad++; $display("FAIL pr_ce_in_pause got=%h exp=0002", d10); end
        press(1'b1, 1'b0);
        total++; if (run10 !== 1'b1) begin bad++; $display("FAIL pr_resumed got=%b exp=1", run10); end
        ce_n(7);
        total++; if (d10 !== 16'h0003) begin bad++; $display("FAIL pr_after_resume got=%h exp=0003", d10); end
    endtask

    task automatic test_ce_on_transition();
        do_reset();
        press(1'b1, 1'b0);
        ce_n(9);
        // Pause edge coincides with a CE that would complete the prescale.
        ss = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        ce = 1'b1;
        @(posedge clk);
        #1;
        ce = 1'b0;
        total++; if (run10 !== 1'b0) begin bad++; $display("FAIL tr_pause_state got=%b exp=0", run10); end
        total++; if (d10 !== 16'h0000) begin bad++; $display("FAIL tr_ce_on_pause got=%h exp=0000", d10); end
        repeat (2) @(posedge clk);
        #1;
        ss = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // Resume edge coincides with a CE; state sampled is PAUSE.
        ss = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        ce = 1'b1;
        @(posedge clk);
        #1;
        ce = 1'b0;
        total++; if (run10 !== 1'b1) begin bad++; $display("FAIL tr_resume_state got=%b exp=1", run10); end
        total++; if (d10 !== 16'h0000) begin bad++; $display("FAIL tr_ce_on_resume got=%h exp=0000", d10); end
        repeat (2) @(posedge clk);
        #1;
        ss = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        ce_n(1);
        total++; if (d10 !== 16'h0001) begin bad++; $display("FAIL tr_prescale_kept got=%h exp=0001", d10); end
    endtask

    task automatic test_wrap();
        do_reset();
        press(1'b1, 1'b0);
        ce_n(9999);
        total++; if (d1 !== 16'h9999) begin bad++; $display("FAIL wrap_9999 got=%h exp=9999", d1); end
        total++; if (ovf1 !== 1'b0) begin bad++; $display("FAIL wrap_ovf_before got=%b exp=0", ovf1); end
        ce_n(1);
        total++; if (d1 !== 16'h0000) begin bad++; $display("FAIL wrap_zero got=%h exp=0000", d1); end
        total++; if (ovf1 !== 1'b1) begin bad++; $display("FAIL wrap_ovf_set got=%b exp=1", ovf1); end
        ce_n(5);
        total++; if (d1 !== 16'h0005) begin bad++; $display("FAIL wrap_continue got=%h exp=0005", d1); end
        total++; if (ovf1 !== 1'b1) begin bad++; $display("FAIL wrap_ovf_sticky got=%b exp=1", ovf1); end
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        total++; if (ovf1 !== 1'b0) begin bad++; $display("FAIL wrap_ovf_cleared got=%b exp=0", ovf1); end
        total++; if (d1 !== 16'h0000) begin bad++; $display("FAIL wrap_digits_cleared got=%h exp=0000", d1); end
    endtask

    task automatic test_clear();
        do_reset();
        press(1'b1, 1'b0);
        ce_n(15);
        press(1'b0, 1'b1);
        total++; if (d10 !== 16'h0001) begin bad++; $display("FAIL clr_in_run_digits got=%h exp=0001", d10); end
        total++; if (run10 !== 1'b1) begin bad++; $display("FAIL clr_in_run_state got=%b exp=1", run10); end
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        total++; if (d10 !== 16'h0000) begin bad++; $display("FAIL clr_in_pause_digits got=%h exp=0000", d10); end
        total++; if (run10 !== 1'b0) begin bad++; $display("FAIL clr_in_pause_state got=%b exp=0", run10); end
        total++; if (ovf10 !== 1'b0) begin bad++; $display("FAIL clr_in_pause_ovf got=%b exp=0", ovf10); end
        // Cleared prescaler: 10 CE from IDLE->RUN gives exactly one count.
        press(1'b1, 1'b0);
        ce_n(10);
        total++; if (d10 !== 16'h0001) begin bad++; $display("FAIL clr_prescale_zero got=%h exp=0001", d10); end
        press(1'b1, 1'b0);
        press(1'b1, 1'b1);
        total++; if (run10 !== 1'b0) begin bad++; $display("FAIL both_in_pause_state got=%b exp=0", run10); end
        total++; if (d10 !== 16'h0000) begin bad++; $display("FAIL both_in_pause_digits got=%h exp=0000", d10); end
        press(1'b1, 1'b1);
        total++; if (run10 !== 1'b1) begin bad++; $display("FAIL both_in_idle_state got=%b exp=1", run10); end
        ce_n(10);
        total++; if (d10 !== 16'h0001) begin bad++; $display("FAIL both_in_idle_count got=%h exp=0001", d10); end
    endtask

    task automatic test_async_reset();
        do_reset();
        press(1'b1, 1'b0);
        ce_n(4120);
        total++; if (d10 !== 16'h0412) begin bad++; $display("FAIL ar_reach_0412 got=%h exp=0412", d10); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (d10 !== 16'h0000) begin bad++; $display("FAIL ar_digits got=%h exp=0000", d10); end
        total++; if (run10 !== 1'b0) begin bad++; $display("FAIL ar_running got=%b exp=0", run10); end
        total++; if (ovf10 !== 1'b0) begin bad++; $display("FAIL ar_ovf got=%b exp=0", ovf10); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        ce_n(10);
        total++; if (d10 !== 16'h0000) begin bad++; $display("FAIL ar_ce_idle got=%h exp=0000", d10); end
        total++; if (run10 !== 1'b0) begin bad++; $display("FAIL ar_still_idle got=%b exp=0", run10); end
        press(1'b1, 1'b0);
        ce_n(10);
        total++; if (d10 !== 16'h0001) begin bad++; $display("FAIL ar_restart got=%h exp=0001", d10); end
    endtask

    task automatic test_button_latency();
        int changes;
        logic last;
        do_reset();
        ss = 1'b1;
        @(posedge clk);
        #1;
        total++; if (run10 !== 1'b0) begin bad++; $display("FAIL lat_edge1 got=%b exp=0", run10); end
        @(posedge clk);
        #1;
        total++; if (run10 !== 1'b0) begin bad++; $display("FAIL lat_edge2 got=%b exp=0", run10); end
        @(posedge clk);
        #1;
        total++; if (run10 !== 1'b1) begin bad++; $display("FAIL lat_edge3 got=%b exp=1", run10); end
        changes = 0;
        last = run10;
        for (int i = 0; i < 97; i++) begin
            @(posedge clk);
            #1;
            if (run10 !== last) changes++;
            last = run10;
        end
        total++; if (changes !== 0 || run10 !== 1'b1) begin bad++; $display("FAIL lat_held_single_event got=%0d/%b exp=0/1", changes, run10); end
        ss = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_count();
        test_pause_resume();
        test_ce_on_transition();
        test_wrap();
        test_clear();
        test_async_reset();
        test_button_latency();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
